// File: rtl/output_bit_eval_sched.sv
// Purpose: round-robin time-multiplexer sharing one combinational output-bit cluster among NREQ requesters.
// Latency: grant at T, cl_i driven from T+1, cl_o sampled at end of T+SETTLE, rsp_valid from T+SETTLE+1.
// Backpressure: RESP holds rsp_valid/rsp_vec/rsp_id/cl_i stable until rsp_ready; no grants while busy.
module output_bit_eval_sched #(
  parameter int NREQ   = 4,
  parameter int IN_W   = 1894,
  parameter int OUT_W  = 128,
  parameter int SETTLE = 2,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*IN_W-1:0] req_vec,
  output logic [IN_W-1:0]      cl_i,
  input  logic [OUT_W-1:0]     cl_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OUT_W-1:0]     rsp_vec,
  output logic                 busy,
  output logic [31:0]          eval_cnt
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_cnt;
  logic [IN_W-1:0]    r_cl_i;
  logic [OUT_W-1:0]   r_rsp_vec;
  logic [31:0]        r_eval_cnt;

  logic               w_gnt_any;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_take;
  logic               w_done;
  logic [ID_W-1:0]    w_rr_next;

  // Circular priority search: first valid requester at or after r_rr_ptr.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  // Pointer moves to the requester after the one just served, wrapping at NREQ.
  assign w_rr_next = (r_id == ID_W'(NREQ - 1)) ? '0 : r_id + ID_W'(1);

  // Next-state and handshake outputs; rst_n gates the handshakes so nothing is accepted or offered in reset.
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_done       = 1'b0;
    req_ready    = '0;
    rsp_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          w_next_state        = ST_SETTLE;
          w_take              = rst_n;
          req_ready[w_gnt_id] = rst_n;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = rst_n;
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
          w_done       = rst_n;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: capture winner's vector, count settle cycles, sample cluster output, retire responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_cnt      <= '0;
      r_cl_i     <= '0;
      r_rsp_vec  <= '0;
      r_eval_cnt <= '0;
    end else begin
      if (w_take) begin
        r_cl_i <= req_vec[w_gnt_id * IN_W +: IN_W];
        r_id   <= w_gnt_id;
        r_cnt  <= CNT_W'(SETTLE - 1);
      end
      if (r_state == ST_SETTLE) begin
        if (r_cnt == '0) begin
          r_rsp_vec <= cl_o;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
      if (w_done) begin
        r_rr_ptr <= w_rr_next;
        if (r_eval_cnt != 32'hFFFF_FFFF) begin
          r_eval_cnt <= r_eval_cnt + 32'd1;
        end
      end
    end
  end

  assign cl_i     = r_cl_i;
  assign rsp_id   = r_id;
  assign rsp_vec  = r_rsp_vec;
  assign busy     = (r_state != ST_IDLE);
  assign eval_cnt = r_eval_cnt;

endmodule

// File: tb/tb_output_bit_eval_sched.sv
// Purpose: directed self-checking bench for output_bit_eval_sched with a one-cycle-delay cluster model.
// Latency: the cluster model output follows cl_i by one clock, so only an on-time sample sees the new vector.
// Backpressure: rsp_ready is driven low for a stretch to check that the response holds.
module tb_output_bit_eval_sched;
  localparam int NREQ   = 4;
  localparam int IN_W   = 1894;
  localparam int OUT_W  = 128;
  localparam int SETTLE = 2;
  localparam int ID_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IN_W-1:0] req_vec;
  logic [IN_W-1:0]      cl_i;
  logic [OUT_W-1:0]     cl_o;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [OUT_W-1:0]     rsp_vec;
  logic                 busy;
  logic [31:0]          eval_cnt;

  logic [IN_W-1:0]      v [NREQ];
  logic [IN_W-1:0]      m_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_vec
    assign req_vec[g*IN_W +: IN_W] = v[g];
  end

  // Cluster model: registered one clock behind cl_i, o[0] = i[75], o[127:1] = i[127:1].
  always @(posedge clk) m_q <= cl_i;
  assign cl_o = {m_q[127:1], m_q[75]};

  output_bit_eval_sched #(
    .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .cl_i(cl_i), .cl_o(cl_o), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_vec(rsp_vec), .busy(busy),
    .eval_cnt(eval_cnt)
  );

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] mk(input logic [31:0] s);
    logic [IN_W-1:0] x;
    x          = '0;
    x[127:0]   = {s, ~s, s ^ 32'h5A5A_5A5A, s + 32'd1};
    x[1000]    = s[0];
    x[IN_W-1]  = 1'b1;
    return x;
  endfunction

  function automatic logic [OUT_W-1:0] exp_rsp(input logic [IN_W-1:0] x);
    return {x[127:1], x[75]};
  endfunction

  function automatic int oh2i(input logic [NREQ-1:0] x);
    for (int i = 0; i < NREQ; i++) if (x[i]) return i;
    return -1;
  endfunction

  // Advance until the scheduler is idle again, bounded.
  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 128'(ok), 128'd1);
  endtask

  // Advance until rsp_valid is seen, bounded.
  task automatic wait_rsp(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 128'(ok), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ngr;
    int         last;
    int         gid;
    int         qid [$];
    bit         seen;

    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int g = 0; g < NREQ; g++) v[g] = mk(32'h1000_0000 * (g + 1) + 32'h0123_4567 * g);
    v[2][75] = 1'b1;
    v[0][75] = 1'b0;

    // Reset state
    tick(); tick();
    #1;
    check_eq("rst_req_ready", 128'(req_ready), 128'd0);
    check_eq("rst_cl_i",      128'(cl_i == '0), 128'd1);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_rsp_id",    128'(rsp_id), 128'd0);
    check_eq("rst_rsp_vec",   128'(rsp_vec), 128'd0);
    check_eq("rst_busy",      128'(busy), 128'd0);
    check_eq("rst_eval_cnt",  128'(eval_cnt), 128'd0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    req_valid = 4'b0100;
    #1;
    check_eq("single_ready_T", 128'(req_ready), 128'b0100);
    tick();
    req_valid = '0;
    #1;
    check_eq("single_busy_T1", 128'(busy), 128'd1);
    check_eq("single_cl_i_T1", 128'(cl_i == v[2]), 128'd1);
    check_eq("single_nrsp_T1", 128'(rsp_valid), 128'd0);
    tick(); #1;
    check_eq("single_nrsp_T2", 128'(rsp_valid), 128'd0);
    tick(); #1;
    check_eq("single_rsp_T3",  128'(rsp_valid), 128'd1);
    check_eq("single_rsp_id",  128'(rsp_id), 128'd2);
    check_eq("single_bit0",    128'(rsp_vec[0]), 128'd1);
    check_eq("single_rsp_vec", 128'(rsp_vec), 128'(exp_rsp(v[2])));
    tick(); #1;
    check_eq("single_idle_T4", 128'(busy), 128'd0);
    check_eq("single_eval",    128'(eval_cnt), 128'd1);
    check_eq("single_nrsp_T4", 128'(rsp_valid), 128'd0);

    // Round-robin with all requesters valid
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    ngr  = 0;
    last = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      #1;
      if (rsp_valid) begin
        if (qid.size() == 0) check_eq("rr_rsp_orphan", 128'd1, 128'd0);
        else begin
          gid = qid.pop_front();
          check_eq("rr_rsp_id",  128'(rsp_id), 128'(gid));
          check_eq("rr_rsp_vec", 128'(rsp_vec), 128'(exp_rsp(v[gid])));
        end
      end
      if (req_ready != '0) begin
        gid = oh2i(req_ready);
        check_eq("rr_grant_id", 128'(gid), 128'(ngr % NREQ));
        if (ngr > 0) check_eq("rr_spacing", 128'(c - last), 128'(SETTLE + 2));
        last = c;
        qid.push_back(gid);
        ngr++;
      end
      if (ngr < 5) tick();
    end
    check_eq("rr_count", 128'(ngr), 128'd5);
    tick();
    req_valid = '0;
    for (int c = 0; c < 12 && qid.size() > 0; c++) begin
      #1;
      if (rsp_valid) begin
        gid = qid.pop_front();
        check_eq("rr_rsp_id",  128'(rsp_id), 128'(gid));
        check_eq("rr_rsp_vec", 128'(rsp_vec), 128'(exp_rsp(v[gid])));
      end
      tick();
    end
    check_eq("rr_drain", 128'(qid.size()), 128'd0);
    wait_idle("rr_idle_timeout");
    check_eq("rr_eval", 128'(eval_cnt), 128'd5);

    // Back-pressure: requester 1 served, requester 0 waits behind a stalled response
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check_eq("bp_ready", 128'(req_ready), 128'b0010);
    tick();
    req_valid = 4'b0001;
    wait_rsp("bp_rsp_timeout");
    check_eq("bp_rsp_id",  128'(rsp_id), 128'd1);
    check_eq("bp_rsp_vec", 128'(rsp_vec), 128'(exp_rsp(v[1])));
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      check_eq("bp_hold_valid", 128'(rsp_valid), 128'd1);
      check_eq("bp_hold_vec",   128'(rsp_vec), 128'(exp_rsp(v[1])));
      check_eq("bp_hold_id",    128'(rsp_id), 128'd1);
      check_eq("bp_hold_cl_i",  128'(cl_i == v[1]), 128'd1);
      check_eq("bp_hold_ready", 128'(req_ready), 128'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_eval_before", 128'(eval_cnt), 128'd5);
    tick(); #1;
    check_eq("bp_rsp_dropped", 128'(rsp_valid), 128'd0);
    check_eq("bp_eval_after",  128'(eval_cnt), 128'd6);
    check_eq("bp_next_grant",  128'(req_ready), 128'b0001);
    tick();
    req_valid = '0;
    wait_idle("bp_idle_timeout");
    check_eq("bp_eval_final", 128'(eval_cnt), 128'd7);

    // Reset in the middle of SETTLE
    req_valid = 4'b1000;
    #1;
    check_eq("mid_ready", 128'(req_ready), 128'b1000);
    tick();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_eq("mid_rst_ready", 128'(req_ready), 128'd0);
    check_eq("mid_rst_rsp",   128'(rsp_valid), 128'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    #1;
    check_eq("mid_busy",    128'(busy), 128'd0);
    check_eq("mid_cl_i",    128'(cl_i == '0), 128'd1);
    check_eq("mid_rsp_vec", 128'(rsp_vec), 128'd0);
    check_eq("mid_rsp_id",  128'(rsp_id), 128'd0);
    check_eq("mid_eval",    128'(eval_cnt), 128'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) seen = 1'b1;
      tick(); #1;
    end
    check_eq("mid_no_rsp", 128'(seen), 128'd0);
    req_valid = 4'b1111;
    #1;
    check_eq("mid_grant0", 128'(req_ready), 128'b0001);
    tick();
    req_valid = '0;
    wait_rsp("mid_rsp_timeout");
    check_eq("mid_rsp_id2",  128'(rsp_id), 128'd0);
    check_eq("mid_rsp_vec2", 128'(rsp_vec), 128'(exp_rsp(v[0])));
    tick(); #1;
    check_eq("mid_eval2", 128'(eval_cnt), 128'd1);

    // Saturating response counter
    force dut.r_eval_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_eval_cnt;
    #1;
    check_eq("sat_preload", 128'(eval_cnt), 128'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0001 << k;
      tick();
      req_valid = '0;
      wait_idle("sat_idle_timeout");
      check_eq("sat_eval", 128'(eval_cnt), 128'hFFFF_FFFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
